// File: rtl/gpio_cond_pkg.sv
// gpio_cond_pkg: shared widths and types for the GPIO input conditioner
package gpio_cond_pkg;
  localparam int GPIO_PORTWIDTH = 16;
  localparam int GPIO_CNT_W = 8;
  localparam int GPIO_PRE_W = 16;
  typedef logic [GPIO_CNT_W-1:0] db_cnt_t;
endpackage

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: per-pin synchroniser plus tick-sampled debounce filter
module gpio_pin_filter
  import gpio_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = GPIO_CNT_W,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             pad,
  input  logic             tick,
  input  logic             dben,
  input  logic             mask,
  input  logic [CNT_W-1:0] thresh,
  output logic             filt
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] nxt;
  logic sync, accept;
  assign sync = sync_q[SYNC_STAGES-1];
  assign nxt = {1'b0, cnt} + (CNT_W+1)'(1);
  // a zero threshold always satisfies the compare, so it acts like one
  assign accept = nxt >= {1'b0, thresh};
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
      cnt <= '0;
      filt <= RESET_BIT;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      if (mask || !dben) begin
        cnt <= '0;
        if (!dben) filt <= sync;
      end else if (tick) begin
        if (sync == filt) cnt <= '0;
        else if (accept) begin
          filt <= sync;
          cnt <= '0;
        end else cnt <= &cnt ? cnt : nxt[CNT_W-1:0];
      end
    end
endmodule

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: pad-side PORTIN stage with sync, debounce, masking and edge pulses
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int PORTWIDTH = GPIO_PORTWIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = GPIO_CNT_W,
  parameter int PRE_W = GPIO_PRE_W,
  parameter logic [PORTWIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [PORTWIDTH-1:0] PAD_IN,
  input  logic [PORTWIDTH-1:0] PORTEN,
  input  logic [PORTWIDTH-1:0] DBEN,
  input  logic [CNT_W-1:0]     DB_THRESH,
  input  logic [PRE_W-1:0]     PRESCALE,
  output logic [PORTWIDTH-1:0] PORTIN_CLEAN,
  output logic [PORTWIDTH-1:0] RISE_PULSE,
  output logic [PORTWIDTH-1:0] FALL_PULSE,
  output logic                 TICK
);
  logic [PRE_W-1:0] pre_cnt;
  logic [PORTWIDTH-1:0] filt, prev;
  // >= compare lets a lowered PRESCALE wrap immediately instead of locking up
  assign TICK = HRESETn & (pre_cnt >= PRESCALE);
  assign PORTIN_CLEAN = filt & ~PORTEN;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      pre_cnt <= '0;
      prev <= RESET_VAL;
      RISE_PULSE <= '0;
      FALL_PULSE <= '0;
    end else begin
      pre_cnt <= TICK ? '0 : pre_cnt + PRE_W'(1);
      prev <= PORTIN_CLEAN;
      RISE_PULSE <= PORTIN_CLEAN & ~prev;
      FALL_PULSE <= ~PORTIN_CLEAN & prev;
    end
  for (genvar g = 0; g < PORTWIDTH; g++) begin : g_pin
    gpio_pin_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W(CNT_W),
      .RESET_BIT(RESET_VAL[g])
    ) u_pin (
      .HCLK(HCLK),
      .HRESETn(HRESETn),
      .pad(PAD_IN[g]),
      .tick(TICK),
      .dben(DBEN[g]),
      .mask(PORTEN[g]),
      .thresh(DB_THRESH),
      .filt(filt[g])
    );
  end
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner: randomized scoreboard bench against a behavioural pin model
module tb_gpio_input_conditioner;
  localparam int PW = 16, SS = 2, CW = 8, PRW = 16;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic [PW-1:0] PAD_IN = 16'hFFFF, PORTEN = '0, DBEN = '0;
  logic [CW-1:0] DB_THRESH = '0;
  logic [PRW-1:0] PRESCALE = '0;
  logic [PW-1:0] PORTIN_CLEAN, RISE_PULSE, FALL_PULSE;
  logic TICK;

  gpio_input_conditioner dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PAD_IN(PAD_IN), .PORTEN(PORTEN), .DBEN(DBEN),
    .DB_THRESH(DB_THRESH), .PRESCALE(PRESCALE), .PORTIN_CLEAN(PORTIN_CLEAN),
    .RISE_PULSE(RISE_PULSE), .FALL_PULSE(FALL_PULSE), .TICK(TICK)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [PW-1:0] clean, rise, fall;
    logic tick;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0, errors = 0;

  logic [PW-1:0] hist[$];
  logic [PW-1:0] m_filt, m_prev, m_rise, m_fall;
  int m_cnt[PW];
  int m_pre;

  logic n_rn = 1'b0;
  logic [PW-1:0] n_pad = 16'hFFFF, n_porten = '0, n_dben = '0;
  logic [CW-1:0] n_th = '0;
  logic [PRW-1:0] n_ps = '0;

  task automatic m_reset();
    hist = {};
    for (int k = 0; k < SS; k++) hist.push_back('0);
    m_filt = '0; m_prev = '0; m_rise = '0; m_fall = '0;
    foreach (m_cnt[j]) m_cnt[j] = 0;
    m_pre = 0;
  endtask

  // what each pin does at one clock edge, given the inputs present at that edge
  task automatic m_edge();
    logic [PW-1:0] s, clean;
    bit tk;
    int need;
    if (!HRESETn) begin
      m_reset();
      return;
    end
    tk = m_pre >= int'(PRESCALE);
    clean = m_filt & ~PORTEN;
    m_rise = clean & ~m_prev;
    m_fall = ~clean & m_prev;
    m_prev = clean;
    s = hist[$];
    need = (DB_THRESH == 0) ? 1 : int'(DB_THRESH);
    for (int j = 0; j < PW; j++) begin
      if (!DBEN[j]) begin
        m_filt[j] = s[j];
        m_cnt[j] = 0;
      end else if (PORTEN[j]) m_cnt[j] = 0;
      else if (tk) begin
        if (s[j] == m_filt[j]) m_cnt[j] = 0;
        else if (m_cnt[j] + 1 >= need) begin
          m_filt[j] = s[j];
          m_cnt[j] = 0;
        end else m_cnt[j] = (m_cnt[j] == 255) ? 255 : m_cnt[j] + 1;
      end
    end
    hist.push_front(PAD_IN);
    void'(hist.pop_back());
    m_pre = tk ? 0 : m_pre + 1;
  endtask

  task automatic step();
    exp_t e;
    @(posedge HCLK);
    m_edge();
    #1;
    HRESETn = n_rn; PAD_IN = n_pad; PORTEN = n_porten; DBEN = n_dben;
    DB_THRESH = n_th; PRESCALE = n_ps;
    if (!n_rn) m_reset();
    e.clean = m_filt & ~PORTEN;
    e.rise = m_rise;
    e.fall = m_fall;
    e.tick = HRESETn && (m_pre >= int'(PRESCALE));
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge HCLK)
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("clean", PORTIN_CLEAN, mon_e.clean);
      chk("rise", RISE_PULSE, mon_e.rise);
      chk("fall", FALL_PULSE, mon_e.fall);
      chk("tick", PW'(TICK), PW'(mon_e.tick));
    end

  initial begin
    logic [PW-1:0] t;
    m_reset();
    repeat (3) step();
    n_rn = 1'b1;
    repeat (8) step();
    n_pad = '0;
    repeat (5) step();
    n_pad = 16'h0008;
    repeat (6) step();
    repeat (200) begin
      n_pad = 16'($urandom);
      n_porten = ($urandom_range(0, 3) == 0) ? 16'($urandom) : '0;
      step();
    end
    n_porten = '0; n_pad = 16'h0020;
    repeat (5) step();
    n_porten = 16'h0020;
    repeat (4) step();
    n_porten = '0;
    repeat (4) step();
    n_dben = 16'hFFFF; n_ps = 16'd9; n_th = 8'd4; n_pad = '0;
    repeat (60) step();
    n_pad = 16'h0001;
    repeat (60) step();
    n_pad = '0;
    repeat (60) step();
    n_pad = 16'h0001;
    repeat (25) step();
    n_pad = '0;
    repeat (60) step();
    repeat (1500) begin
      t = '0;
      for (int j = 0; j < PW; j++) if ($urandom_range(0, 39) == 0) t[j] = 1'b1;
      n_pad ^= t;
      if ($urandom_range(0, 199) == 0) begin
        n_dben = 16'($urandom);
        n_porten = 16'($urandom) & 16'($urandom);
        n_th = 8'($urandom_range(0, 6));
        n_ps = 16'($urandom_range(0, 5));
      end
      step();
    end
    n_porten = '0; n_dben = 16'hFFFF; n_th = 8'd0; n_ps = 16'd3; n_pad = '0;
    repeat (20) step();
    n_pad = 16'hFFFF;
    repeat (12) step();
    n_th = 8'd255; n_ps = 16'd0; n_pad = '0;
    repeat (300) step();
    n_pad = 16'hFFFF;
    repeat (100) step();
    n_pad = '0;
    repeat (5) step();
    n_pad = 16'hFFFF;
    repeat (300) step();
    n_th = 8'd4; n_ps = 16'd100; n_pad = '0;
    repeat (150) step();
    n_ps = 16'd2;
    repeat (20) step();
    n_ps = 16'd9; n_pad = 16'hFFFF;
    repeat (60) step();
    n_pad = '0;
    repeat (25) step();
    n_rn = 1'b0;
    repeat (2) step();
    n_rn = 1'b1;
    repeat (20) step();
    repeat (2) @(posedge HCLK);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
